// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
// Shared definitions for the reset sequencer:
//   - state_e       : FSM state encoding
//   - DEFAULT_*     : default domain count, stagger delay and soft-reset hold
//   - CNT_W         : width of the shared stagger/hold counter
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STAGGER   = 3'd1,
    ST_RUN       = 3'd2,
    ST_SW_HOLD   = 3'd3,
    ST_SW_ACK    = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_NUM_DOMAINS = 4;
  localparam int unsigned DEFAULT_STAGE_DELAY = 16;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 8;

  // One counter serves both the stagger spacing and the soft-reset hold;
  // both delays are limited to 255, so 8 bits never wrap.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i   : destination clock
//   clear_n : asynchronous active-low clear (both flops go to 0)
//   d       : asynchronous input level
//   q       : synchronized level, two clk_i edges of latency
module sync_2ff (
  input  logic clk_i,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk_i or negedge clear_n) begin
    if (!clear_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Releases NUM_DOMAINS downstream resets one at a time, STAGE_DELAY cycles
// apart, once the clock generator reports lock. In RUN, software may request
// a reset of any subset of domains; the selected domains are held in reset
// for HOLD_CYCLES cycles, then a four-phase acknowledge completes the request.
// Loss of lock at any time drops everything back to WAIT_LOCK.
// Ports:
//   clk_i          : sole clock
//   reset_i        : asynchronous active-low reset
//   locked_i       : generator lock, asynchronous to clk_i
//   sw_rst_req_i   : per-domain software reset request (level)
//   sw_rst_ack_o   : software reset acknowledge
//   domain_rst_o   : active-high reset per domain, bit 0 released first
//   all_released_o : high only in RUN
//   busy_o         : high in every state except RUN
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = DEFAULT_NUM_DOMAINS,
  parameter int unsigned STAGE_DELAY = DEFAULT_STAGE_DELAY,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   locked_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic                   sw_rst_ack_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   all_released_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);

  logic                   lock_s;
  state_e                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] mask_reg, mask_next;
  logic [NUM_DOMAINS-1:0] rst_reg, rst_next;
  logic [NUM_DOMAINS-1:0] idx_onehot;

  sync_2ff u_lock_sync (
    .clk_i   (clk_i),
    .clear_n (reset_i),
    .d       (locked_i),
    .q       (lock_s)
  );

  // Decode the domain currently being released into a one-hot clear mask.
  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      if (idx_reg == IDX_W'(i)) begin
        idx_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg <= ST_WAIT_LOCK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      mask_reg  <= '0;
      rst_reg   <= '1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      mask_reg  <= mask_next;
      rst_reg   <= rst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    mask_next  = mask_reg;
    rst_next   = rst_reg;

    // Lock loss outranks every other event, including terminal counts and
    // a pending software request.
    if (!lock_s) begin
      state_next = ST_WAIT_LOCK;
      cnt_next   = '0;
      idx_next   = '0;
      mask_next  = '0;
      rst_next   = '1;
    end else begin
      case (state_reg)
        ST_WAIT_LOCK: begin
          cnt_next   = '0;
          idx_next   = '0;
          rst_next   = '1;
          state_next = ST_STAGGER;
        end

        ST_STAGGER: begin
          if (cnt_reg == CNT_W'(STAGE_DELAY - 1)) begin
            cnt_next = '0;
            rst_next = rst_reg & ~idx_onehot;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == IDX_W'(NUM_DOMAINS - 1)) begin
              state_next = ST_RUN;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_RUN: begin
          if (|sw_rst_req_i) begin
            mask_next  = sw_rst_req_i;
            rst_next   = sw_rst_req_i;
            cnt_next   = '0;
            state_next = ST_SW_HOLD;
          end
        end

        ST_SW_HOLD: begin
          // The request input is not looked at here: the mask captured on
          // entry alone decides which domains are held.
          if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_next   = '0;
            rst_next   = rst_reg & ~mask_reg;
            state_next = ST_SW_ACK;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_SW_ACK: begin
          if (sw_rst_req_i == '0) begin
            mask_next  = '0;
            state_next = ST_RUN;
          end
        end

        default: begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          idx_next   = '0;
          mask_next  = '0;
          rst_next   = '1;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register so they follow
  // the asynchronous reset without waiting for an edge.
  assign domain_rst_o   = rst_reg;
  assign sw_rst_ack_o   = (state_reg == ST_SW_ACK);
  assign all_released_o = (state_reg == ST_RUN);
  assign busy_o         = (state_reg != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters
// (4 domains, 16-cycle stagger, 8-cycle hold).
module tb_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       locked_i;
  logic [3:0] sw_rst_req_i;
  logic       sw_rst_ack_o;
  logic [3:0] domain_rst_o;
  logic       all_released_o;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;

  reset_sequencer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .locked_i       (locked_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .sw_rst_ack_o   (sw_rst_ack_o),
    .domain_rst_o   (domain_rst_o),
    .all_released_o (all_released_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected domain resets e edges after reset/lock release with lock held:
  // lock_s rises at edge 2, STAGGER entered at edge 3, releases at 19/35/51/67.
  function automatic logic [3:0] stag(input int e);
    if (e < 19)      return 4'b1111;
    else if (e < 35) return 4'b1110;
    else if (e < 51) return 4'b1100;
    else if (e < 67) return 4'b1000;
    else             return 4'b0000;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i      = 1'b0;
    locked_i     = 1'b1;
    sw_rst_req_i = 4'b0000;
    tick(3);
    check("reset_rst", domain_rst_o, 4'b1111);
    check("reset_ack", sw_rst_ack_o, 1'b0);
    check("reset_all", all_released_o, 1'b0);
    check("reset_busy", busy_o, 1'b1);

    // Power-up stagger.
    reset_i = 1'b1;
    for (int e = 1; e <= 67; e++) begin
      tick(1);
      check("pwr_rst", domain_rst_o, stag(e));
      check("pwr_all", all_released_o, (e >= 67) ? 1'b1 : 1'b0);
      check("pwr_busy", busy_o, (e >= 67) ? 1'b0 : 1'b1);
    end
    $display("power-up stagger done");

    // Soft reset of domains 0 and 2; request altered mid-hold must be ignored.
    sw_rst_req_i = 4'b0101;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check("soft_rst", domain_rst_o, (k <= 8) ? 4'b0101 : 4'b0000);
      check("soft_ack", sw_rst_ack_o, (k == 9) ? 1'b1 : 1'b0);
      check("soft_busy", busy_o, 1'b1);
      if (k == 3) sw_rst_req_i = 4'b0011;
    end
    tick(3);
    check("soft_ack_held", sw_rst_ack_o, 1'b1);
    check("soft_rst_after", domain_rst_o, 4'b0000);
    sw_rst_req_i = 4'b0000;
    tick(1);
    check("soft_ack_drop", sw_rst_ack_o, 1'b0);
    check("soft_run", all_released_o, 1'b1);
    check("soft_busy_low", busy_o, 1'b0);
    $display("soft reset 0101 done");

    // Lock loss from RUN: synchronizer latency then full reassert.
    locked_i = 1'b0;
    tick(2);
    check("loss_run_lag", domain_rst_o, 4'b0000);
    tick(1);
    check("loss_run_rst", domain_rst_o, 4'b1111);
    check("loss_run_busy", busy_o, 1'b1);

    // Relock, then lose lock again after domain 1 released.
    locked_i = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick(1);
      check("relock_rst", domain_rst_o, stag(e));
    end
    locked_i = 1'b0;
    tick(3);
    check("loss_stag_rst", domain_rst_o, 4'b1111);
    check("loss_stag_busy", busy_o, 1'b1);
    $display("lock loss mid-stagger done");

    // Relock with request 1000 held: ignored during stagger, served in RUN.
    sw_rst_req_i = 4'b1000;
    locked_i     = 1'b1;
    for (int e = 1; e <= 76; e++) begin
      tick(1);
      if (e <= 67)      check("ign_rst", domain_rst_o, stag(e));
      else if (e <= 75) check("ign_hold", domain_rst_o, 4'b1000);
      else              check("ign_done", domain_rst_o, 4'b0000);
      check("ign_ack", sw_rst_ack_o, (e >= 76) ? 1'b1 : 1'b0);
    end
    sw_rst_req_i = 4'b0000;
    tick(1);
    check("ign_ack_drop", sw_rst_ack_o, 1'b0);
    check("ign_run", all_released_o, 1'b1);
    $display("ignored request then soft reset 1000 done");

    // Asynchronous reset between edges during SW_HOLD.
    sw_rst_req_i = 4'b0101;
    tick(4);
    check("async_pre", domain_rst_o, 4'b0101);
    #3;
    reset_i = 1'b0;
    #1;
    check("async_rst", domain_rst_o, 4'b1111);
    check("async_ack", sw_rst_ack_o, 1'b0);
    check("async_busy", busy_o, 1'b1);
    check("async_all", all_released_o, 1'b0);
    tick(1);
    reset_i      = 1'b1;
    sw_rst_req_i = 4'b0000;
    tick(67);
    check("async_rerun", all_released_o, 1'b1);
    check("async_rerun_rst", domain_rst_o, 4'b0000);
    $display("async reset mid-hold done");

    // Lock loss reaching the FSM in the hold terminal-count cycle.
    sw_rst_req_i = 4'b0101;
    tick(1);
    check("sim_entry", domain_rst_o, 4'b0101);
    tick(5);
    locked_i = 1'b0;
    tick(2);
    check("sim_tc_rst", domain_rst_o, 4'b0101);
    check("sim_tc_ack", sw_rst_ack_o, 1'b0);
    tick(1);
    check("sim_rst", domain_rst_o, 4'b1111);
    check("sim_busy", busy_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("sim_no_ack", sw_rst_ack_o, 1'b0);
      check("sim_hold_rst", domain_rst_o, 4'b1111);
      tick(1);
    end
    $display("lock loss at hold terminal count done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
